cnn_layer_accel_wht_seq_ctrl: RTL and testbench

Controller that sequences the CE weight table for one convolution job. It streams 3x3 kernel weights into the table during configuration. During execution it issues per-cycle weight-pair addresses, `ce_execute` strobes and `next_kernel` pulses for every output pixel, stepping through all kernels. It sits between the layer job dispatcher and the weight table, with pixel-level pacing from the row-buffer side.

---
 rtl/cnn_layer_accel_wht_seq_ctrl_if.sv | 51 +++++
 rtl/cnn_layer_accel_wht_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cnn_layer_accel_wht_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_accel_wht_seq_ctrl_if.sv
// Handshake and data bundle between the job dispatcher, weight stream,
// row-buffer pacing and the CE weight table for the weight sequencer.
interface cnn_layer_accel_wht_seq_ctrl_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    // Job dispatcher side
    logic              job_start;
    logic [15:0]       num_kernels;
    logic [15:0]       num_pixels;
    logic              job_accept;
    logic              kernel_config_valid;
    logic              config_mode;
    logic              job_done;

    // Weight stream into the table
    logic              wht_in_valid;
    logic [DATA_W-1:0] wht_in_data;
    logic              wht_in_ready;
    logic              wht_config_wren;
    logic [DATA_W-1:0] wht_config_data;

    // Pixel pacing and execution sequencing
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] wht_seq_addr0;
    logic [ADDR_W-1:0] wht_seq_addr1;
    logic              ce_execute;
    logic              ce_odd_tail;
    logic              next_kernel;

    // Environment side: drives requests and streams, observes the sequencer
    modport master (
        output job_start, num_kernels, num_pixels,
        output wht_in_valid, wht_in_data, pix_valid,
        input  job_accept, kernel_config_valid, config_mode, job_done,
        input  wht_in_ready, wht_config_wren, wht_config_data,
        input  pix_ready, wht_seq_addr0, wht_seq_addr1,
        input  ce_execute, ce_odd_tail, next_kernel
    );

    // Sequencer side
    modport slave (
        input  job_start, num_kernels, num_pixels,
        input  wht_in_valid, wht_in_data, pix_valid,
        output job_accept, kernel_config_valid, config_mode, job_done,
        output wht_in_ready, wht_config_wren, wht_config_data,
        output pix_ready, wht_seq_addr0, wht_seq_addr1,
        output ce_execute, ce_odd_tail, next_kernel
    );
endinterface

// File: rtl/cnn_layer_accel_wht_seq_ctrl.sv
// Weight-table sequencer for one convolution job: loads kernel weights during
// CONFIG, then walks every kernel's weight pairs for each output pixel.
module cnn_layer_accel_wht_seq_ctrl #(
    parameter int unsigned C_KERNEL_WORDS = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    cnn_layer_accel_wht_seq_ctrl_if.slave   bus
);
    localparam int unsigned C_PAIRS = (C_KERNEL_WORDS + 1) / 2;
    localparam int unsigned WC_W    = 10;
    localparam int unsigned K_W     = 6;
    localparam int unsigned P_W     = 16;
    localparam int unsigned PC_W    = 4;
    localparam int unsigned A_W     = 4;
    localparam bit          ODD_KW  = (C_KERNEL_WORDS % 2) == 1;
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(C_PAIRS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_WAIT_PIX,
        S_EXEC,
        S_NEXT_KRN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [K_W-1:0]  k_q, k_d;
    logic [P_W-1:0]  p_q, p_d;
    logic [WC_W-1:0] wc_q, wc_d;
    logic [K_W-1:0]  kc_q, kc_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic            job_accept_q, job_accept_d;
    logic            kcv_q, kcv_d;
    logic            config_mode_q, config_mode_d;
    logic            pix_ready_q, pix_ready_d;
    logic            ce_execute_q, ce_execute_d;
    logic [A_W-1:0]  addr0_q, addr0_d;
    logic [A_W-1:0]  addr1_q, addr1_d;
    logic            odd_tail_q, odd_tail_d;
    logic            next_kernel_q, next_kernel_d;
    logic            job_done_q, job_done_d;

    logic            wht_in_ready_c;
    logic            wht_config_wren_c;
    logic [WC_W-1:0] last_word_c;
    logic            unused_c;

    // Weight stream passes straight through to the table while configuring
    assign wht_in_ready_c    = (state_q == S_CONFIG);
    assign wht_config_wren_c = bus.wht_in_valid & wht_in_ready_c;
    assign last_word_c       = WC_W'((WC_W'(k_q) + WC_W'(1)) * WC_W'(C_KERNEL_WORDS) - WC_W'(1));
    assign unused_c          = ^bus.num_kernels[15:K_W];

    assign bus.wht_in_ready        = wht_in_ready_c;
    assign bus.wht_config_wren     = wht_config_wren_c;
    assign bus.wht_config_data     = bus.wht_in_data;
    assign bus.job_accept          = job_accept_q;
    assign bus.kernel_config_valid = kcv_q;
    assign bus.config_mode         = config_mode_q;
    assign bus.pix_ready           = pix_ready_q;
    assign bus.ce_execute          = ce_execute_q;
    assign bus.wht_seq_addr0       = addr0_q;
    assign bus.wht_seq_addr1       = addr1_q;
    assign bus.ce_odd_tail         = odd_tail_q;
    assign bus.next_kernel         = next_kernel_q;
    assign bus.job_done            = job_done_q;

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            p_q           <= '0;
            wc_q          <= '0;
            kc_q          <= '0;
            pc_q          <= '0;
            job_accept_q  <= 1'b0;
            kcv_q         <= 1'b0;
            config_mode_q <= 1'b0;
            pix_ready_q   <= 1'b0;
            ce_execute_q  <= 1'b0;
            addr0_q       <= '0;
            addr1_q       <= '0;
            odd_tail_q    <= 1'b0;
            next_kernel_q <= 1'b0;
            job_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            p_q           <= p_d;
            wc_q          <= wc_d;
            kc_q          <= kc_d;
            pc_q          <= pc_d;
            job_accept_q  <= job_accept_d;
            kcv_q         <= kcv_d;
            config_mode_q <= config_mode_d;
            pix_ready_q   <= pix_ready_d;
            ce_execute_q  <= ce_execute_d;
            addr0_q       <= addr0_d;
            addr1_q       <= addr1_d;
            odd_tail_q    <= odd_tail_d;
            next_kernel_q <= next_kernel_d;
            job_done_q    <= job_done_d;
        end
    end

    // Next-state, counter updates and output decode (outputs land one cycle later)
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        p_d           = p_q;
        wc_d          = wc_q;
        kc_d          = kc_q;
        pc_d          = pc_q;
        job_accept_d  = 1'b0;
        kcv_d         = 1'b0;
        pix_ready_d   = 1'b0;
        ce_execute_d  = 1'b0;
        addr0_d       = '0;
        addr1_d       = '0;
        odd_tail_d    = 1'b0;
        next_kernel_d = 1'b0;
        job_done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.job_start) begin
                    job_accept_d = 1'b1;
                    kcv_d        = 1'b1;
                    k_d          = bus.num_kernels[K_W-1:0];
                    p_d          = (bus.num_pixels == '0) ? P_W'(1) : bus.num_pixels;
                    wc_d         = '0;
                    state_d      = S_CONFIG;
                end
            end
            S_CONFIG: begin
                if (wht_config_wren_c) begin
                    wc_d = wc_q + WC_W'(1);
                    if (wc_q == last_word_c) begin
                        state_d = S_WAIT_PIX;
                    end
                end
            end
            S_WAIT_PIX: begin
                if (bus.pix_valid) begin
                    pix_ready_d = 1'b1;
                    kc_d        = '0;
                    pc_d        = '0;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                ce_execute_d = 1'b1;
                addr0_d      = A_W'({pc_q, 1'b0});
                addr1_d      = A_W'({pc_q, 1'b1});
                // Odd kernel: last pair repeats the even word and flags DSP1 invalid
                if (ODD_KW && (pc_q == LAST_PC)) begin
                    addr1_d    = A_W'({pc_q, 1'b0});
                    odd_tail_d = 1'b1;
                end
                if (pc_q == LAST_PC) begin
                    state_d = S_NEXT_KRN;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            S_NEXT_KRN: begin
                next_kernel_d = 1'b1;
                if (kc_q < k_q) begin
                    kc_d    = kc_q + K_W'(1);
                    pc_d    = '0;
                    state_d = S_EXEC;
                end else begin
                    p_d     = p_q - P_W'(1);
                    state_d = (p_q == P_W'(1)) ? S_DONE : S_WAIT_PIX;
                end
            end
            S_DONE: begin
                job_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        config_mode_d = (state_d == S_CONFIG);
    end
endmodule

// File: tb/tb_cnn_layer_accel_wht_seq_ctrl.sv
// Directed bench for the weight-table sequencer with a schedule-based model.
module tb_cnn_layer_accel_wht_seq_ctrl;
    localparam int KW = 9;
    localparam int NP = (KW + 1) / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_layer_accel_wht_seq_ctrl_if bus ();

    cnn_layer_accel_wht_seq_ctrl #(.C_KERNEL_WORDS(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       ce;
        logic       pr;
        logic       nk;
        logic       done;
        logic       tail;
        logic       resume;
        logic [3:0] a0;
        logic [3:0] a1;
    } rec_t;

    int n_vec  = 0;
    int n_miss = 0;

    // Model state: expected per-cycle execution schedule plus config bookkeeping
    rec_t sched[$];
    bit   idle     = 1'b1;
    bit   waiting  = 1'b0;
    bit   acc_pend = 1'b0;
    int   cfg_left = 0;
    int   pix_left = 0;
    int   mk       = 0;

    // Observed event counts for the current job
    int c_acc, c_kcv, c_wren, c_ce, c_tail, c_nk, c_pr, c_done;
    int log_a0[$];
    int log_a1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One pixel: pr, then per kernel NP execute cycles and one next_kernel
    task automatic push_pixel();
        rec_t r;
        pix_left--;
        r = '0; r.pr = 1'b1; sched.push_back(r);
        for (int k = 0; k <= mk; k++) begin
            for (int p = 0; p < NP; p++) begin
                r      = '0;
                r.ce   = 1'b1;
                r.a0   = 4'(2 * p);
                r.a1   = (2 * p + 1 < KW) ? 4'(2 * p + 1) : 4'(2 * p);
                r.tail = (2 * p + 1 >= KW);
                sched.push_back(r);
            end
            r        = '0;
            r.nk     = 1'b1;
            r.resume = (k == mk) && (pix_left > 0);
            sched.push_back(r);
        end
        if (pix_left == 0) begin
            r = '0; r.done = 1'b1; sched.push_back(r);
        end
    endtask

    // Per-cycle compare against the model, then advance the model
    task automatic compare_cycle();
        rec_t e;
        bit   cfg_end;
        bit   cfg_on;
        e       = '0;
        cfg_end = 1'b0;
        chk("cfg_data_pass", 32'(bus.wht_config_data), 32'(bus.wht_in_data));
        if (rst) begin
            chk("reset_outputs", 32'({bus.job_accept, bus.kernel_config_valid, bus.config_mode,
                bus.wht_in_ready, bus.wht_config_wren, bus.pix_ready, bus.wht_seq_addr0,
                bus.wht_seq_addr1, bus.ce_execute, bus.ce_odd_tail, bus.next_kernel,
                bus.job_done}), 32'd0);
            sched.delete();
            idle = 1'b1; waiting = 1'b0; acc_pend = 1'b0; cfg_left = 0; pix_left = 0;
            return;
        end
        if (sched.size() > 0) e = sched.pop_front();
        cfg_on = (cfg_left > 0);
        chk("ce_execute", 32'(bus.ce_execute), 32'(e.ce));
        if (e.ce) begin
            chk("addr0", 32'(bus.wht_seq_addr0), 32'(e.a0));
            chk("addr1", 32'(bus.wht_seq_addr1), 32'(e.a1));
        end
        chk("ce_odd_tail", 32'(bus.ce_odd_tail), 32'(e.tail));
        chk("next_kernel", 32'(bus.next_kernel), 32'(e.nk));
        chk("pix_ready", 32'(bus.pix_ready), 32'(e.pr));
        chk("job_done", 32'(bus.job_done), 32'(e.done));
        chk("job_accept", 32'(bus.job_accept), 32'(acc_pend));
        chk("kernel_config_valid", 32'(bus.kernel_config_valid), 32'(acc_pend));
        chk("config_mode", 32'(bus.config_mode), 32'(cfg_on));
        chk("wht_in_ready", 32'(bus.wht_in_ready), 32'(cfg_on));
        chk("wht_config_wren", 32'(bus.wht_config_wren), 32'(cfg_on && bus.wht_in_valid));

        c_acc  += int'(bus.job_accept);
        c_kcv  += int'(bus.kernel_config_valid);
        c_wren += int'(bus.wht_config_wren);
        c_ce   += int'(bus.ce_execute);
        c_tail += int'(bus.ce_odd_tail);
        c_nk   += int'(bus.next_kernel);
        c_pr   += int'(bus.pix_ready);
        c_done += int'(bus.job_done);
        if (bus.ce_execute) begin
            log_a0.push_back(int'(bus.wht_seq_addr0));
            log_a1.push_back(int'(bus.wht_seq_addr1));
        end

        if (e.done)   idle    = 1'b1;
        if (e.resume) waiting = 1'b1;
        acc_pend = 1'b0;
        if (idle && bus.job_start) begin
            acc_pend = 1'b1;
            idle     = 1'b0;
            mk       = int'(bus.num_kernels[5:0]);
            cfg_left = (mk + 1) * KW;
            pix_left = (bus.num_pixels == 16'd0) ? 1 : int'(bus.num_pixels);
        end else if (cfg_left > 0 && bus.wht_in_valid) begin
            cfg_left--;
            if (cfg_left == 0) cfg_end = 1'b1;
        end
        if (waiting && bus.pix_valid) begin
            waiting = 1'b0;
            push_pixel();
        end
        if (cfg_end) waiting = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        c_acc = 0; c_kcv = 0; c_wren = 0; c_ce = 0; c_tail = 0; c_nk = 0; c_pr = 0; c_done = 0;
        log_a0.delete();
        log_a1.delete();
    endtask

    int ce_before_pix;
    int nk_before_pix;

    // Run one job; optional valid toggling, late pix_valid, start poke, abort
    task automatic run_job(input logic [15:0] nk, input logic [15:0] np, input bit toggle,
                           input int pix_low, input bit poke, input int abort_ce);
        bit fin;
        bit poked;
        fin   = 1'b0;
        poked = 1'b0;
        clear_counts();
        ce_before_pix = -1;
        nk_before_pix = -1;
        bus.num_kernels  = nk;
        bus.num_pixels   = np;
        bus.job_start    = 1'b1;
        bus.wht_in_valid = 1'b0;
        bus.pix_valid    = 1'b0;
        cyc();
        bus.job_start = 1'b0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            bus.wht_in_valid = toggle ? (i % 2 == 0) : 1'b1;
            bus.wht_in_data  = 16'($urandom);
            bus.pix_valid    = (i >= pix_low);
            bus.job_start    = 1'b0;
            if (i == pix_low) begin
                ce_before_pix = c_ce;
                nk_before_pix = c_nk;
            end
            if (poke && !poked && c_ce >= 2) begin
                bus.job_start = 1'b1;
                poked = 1'b1;
            end
            if (abort_ce > 0 && c_ce >= abort_ce) return;
            cyc();
            if (c_done > 0) fin = 1'b1;
        end
        if (!fin) chk("job_timeout", 32'd0, 32'd1);
        bus.wht_in_valid = 1'b0;
        bus.pix_valid    = 1'b0;
        bus.job_start    = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        rst              = 1'b1;
        bus.job_start    = 1'b0;
        bus.num_kernels  = '0;
        bus.num_pixels   = '0;
        bus.wht_in_valid = 1'b0;
        bus.wht_in_data  = 16'h1234;
        bus.pix_valid    = 1'b0;
        clear_counts();
        repeat (3) cyc();
        chk("reset_config_mode", 32'(bus.config_mode), 32'd0);
        chk("reset_ce_execute", 32'(bus.ce_execute), 32'd0);
        rst = 1'b0;
        repeat (2) cyc();

        // Single kernel, single pixel
        run_job(16'd0, 16'd1, 1'b0, 0, 1'b0, 0);
        chk("t1_accept", 32'(c_acc), 32'd1);
        chk("t1_kcv", 32'(c_kcv), 32'd1);
        chk("t1_wren", 32'(c_wren), 32'd9);
        chk("t1_ce", 32'(c_ce), 32'd5);
        chk("t1_tail", 32'(c_tail), 32'd1);
        chk("t1_nk", 32'(c_nk), 32'd1);
        chk("t1_done", 32'(c_done), 32'd1);
        chk("t1_addr_count", 32'(log_a0.size()), 32'd5);
        begin
            int ea0[5] = '{0, 2, 4, 6, 8};
            int ea1[5] = '{1, 3, 5, 7, 8};
            for (int i = 0; i < 5 && i < log_a0.size(); i++) begin
                chk("t1_addr0_lit", 32'(log_a0[i]), 32'(ea0[i]));
                chk("t1_addr1_lit", 32'(log_a1[i]), 32'(ea1[i]));
            end
        end

        // Four kernels, two pixels
        run_job(16'd3, 16'd2, 1'b0, 0, 1'b0, 0);
        chk("t2_wren", 32'(c_wren), 32'd36);
        chk("t2_nk", 32'(c_nk), 32'd8);
        chk("t2_ce", 32'(c_ce), 32'd40);
        chk("t2_pix_ready", 32'(c_pr), 32'd2);
        chk("t2_done", 32'(c_done), 32'd1);

        // Weight valid every other cycle
        run_job(16'd1, 16'd1, 1'b1, 0, 1'b0, 0);
        chk("t3_wren", 32'(c_wren), 32'd18);
        chk("t3_nk", 32'(c_nk), 32'd2);

        // Late pix_valid and an ignored job_start during execution
        run_job(16'd0, 16'd1, 1'b0, 32, 1'b1, 0);
        chk("t4_ce_before_pix", 32'(ce_before_pix), 32'd0);
        chk("t4_nk_before_pix", 32'(nk_before_pix), 32'd0);
        chk("t4_accept", 32'(c_acc), 32'd1);
        chk("t4_ce", 32'(c_ce), 32'd5);

        // Reset in the middle of execution, then a clean job
        run_job(16'd2, 16'd3, 1'b0, 0, 1'b0, 3);
        rst = 1'b1;
        #1;
        chk("t5_async_ce", 32'(bus.ce_execute), 32'd0);
        chk("t5_async_addr", 32'({bus.wht_seq_addr0, bus.wht_seq_addr1}), 32'd0);
        chk("t5_async_ready", 32'(bus.wht_in_ready), 32'd0);
        chk("t5_async_done", 32'(bus.job_done), 32'd0);
        repeat (2) cyc();
        chk("t5_no_done", 32'(c_done), 32'd0);
        rst = 1'b0;
        cyc();
        run_job(16'd0, 16'd1, 1'b0, 0, 1'b0, 0);
        chk("t5_post_ce", 32'(c_ce), 32'd5);
        chk("t5_post_done", 32'(c_done), 32'd1);

        // Zero pixels and ignored upper kernel bits
        run_job(16'h0041, 16'd0, 1'b0, 0, 1'b0, 0);
        chk("t6_nk", 32'(c_nk), 32'd2);
        chk("t6_pix_ready", 32'(c_pr), 32'd1);
        chk("t6_wren", 32'(c_wren), 32'd18);
        chk("t6_ce", 32'(c_ce), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
